// File: rtl/call_button_conditioner.sv
// Two independent push-button front-end channels (call, cancel): two-flop
// synchronizer, counter debounce, and a registered one-cycle pulse on each accepted press.
module call_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic call_btn,
  input  logic cancel_btn,
  output logic call,
  output logic cancel,
  output logic call_level,
  output logic cancel_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Bit 0 is the call channel, bit 1 the cancel channel.
  logic [1:0]       btn_s;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       level_r;
  logic [1:0]       pulse_r;
  logic [1:0]       level_nxt_s;
  logic [1:0]       pulse_nxt_s;
  logic [CNT_W-1:0] cnt_r     [2];
  logic [CNT_W-1:0] cnt_nxt_s [2];

  assign btn_s = {cancel_btn, call_btn};

  // Debounce decision per channel; any agreeing cycle restarts the count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_nxt_s[i] = level_r[i];
      pulse_nxt_s[i] = 1'b0;
      cnt_nxt_s[i]   = {CNT_W{1'b0}};
      if (sync2_r[i] == level_r[i]) begin
        cnt_nxt_s[i]   = {CNT_W{1'b0}};
      end else if (cnt_r[i] == CNT_MAX) begin
        // Pulse only when the accepted level is a press (0->1).
        level_nxt_s[i] = sync2_r[i];
        pulse_nxt_s[i] = sync2_r[i];
      end else begin
        cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Synchronizer, debounce state and output pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r  <= 2'b00;
      sync2_r  <= 2'b00;
      level_r  <= 2'b00;
      pulse_r  <= 2'b00;
      cnt_r[0] <= {CNT_W{1'b0}};
      cnt_r[1] <= {CNT_W{1'b0}};
    end else begin
      sync1_r  <= btn_s;
      sync2_r  <= sync1_r;
      level_r  <= level_nxt_s;
      pulse_r  <= pulse_nxt_s;
      cnt_r[0] <= cnt_nxt_s[0];
      cnt_r[1] <= cnt_nxt_s[1];
    end
  end

  assign call         = pulse_r[0];
  assign cancel       = pulse_r[1];
  assign call_level   = level_r[0];
  assign cancel_level = level_r[1];

endmodule

// File: tb/tb_call_button_conditioner.sv
// Self-checking bench for call_button_conditioner at DEBOUNCE_CYCLES=4:
// per-cycle vector table plus hand-written multi-cycle sequences, via a scoreboard queue.
module tb_call_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic call_btn = 1'b0;
  logic cancel_btn = 1'b0;
  logic call, cancel, call_level, cancel_level;

  typedef struct {
    logic       rst;
    logic       cb;
    logic       xb;
    logic [3:0] exp;   // {call, cancel, call_level, cancel_level}
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb_q[$];
  int         checks = 0;
  int         errors = 0;
  string      names [4] = '{"cancel_level", "call_level", "cancel", "call"};

  call_button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .call_btn     (call_btn),
    .cancel_btn   (cancel_btn),
    .call         (call),
    .cancel       (cancel),
    .call_level   (call_level),
    .cancel_level (cancel_level)
  );

  always #5 clk = ~clk;

  function automatic void add(input int n, input logic r, input logic cb, input logic xb,
                              input logic [3:0] e);
    vec_t v;
    v.rst = r; v.cb = cb; v.xb = xb; v.exp = e;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  // Drive inputs on the falling edge, push the expectation, compare just after the rising edge.
  task automatic step(input logic r, input logic cb, input logic xb, input logic [3:0] e,
                      input string tag);
    logic [3:0] got;
    logic [3:0] want;
    @(negedge clk);
    rst = r; call_btn = cb; cancel_btn = xb;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {call, cancel, call_level, cancel_level};
    want = sb_q.pop_front();
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got[b] !== want[b]) begin
        errors++;
        $display("FAIL %s %s at %0t: got %b expected %b", tag, names[b], $time, got[b], want[b]);
      end
    end
  endtask

  task automatic hold(input int n, input logic r, input logic cb, input logic xb,
                      input logic [3:0] e, input string tag);
    for (int k = 0; k < n; k++) step(r, cb, xb, e, tag);
  endtask

  initial begin
    // Reset held with call pressed, then the button is treated as a fresh press.
    add(3, 1'b1, 1'b1, 1'b0, 4'b0000);
    add(5, 1'b0, 1'b1, 1'b0, 4'b0000);
    add(1, 1'b0, 1'b1, 1'b0, 4'b1010);
    add(2, 1'b0, 1'b1, 1'b0, 4'b0010);
    // Release: level falls five edges after the first low sample, no pulse.
    add(5, 1'b0, 1'b0, 1'b0, 4'b0010);
    add(2, 1'b0, 1'b0, 1'b0, 4'b0000);
    // Simultaneous clean press held 20 cycles.
    add(5, 1'b0, 1'b1, 1'b1, 4'b0000);
    add(1, 1'b0, 1'b1, 1'b1, 4'b1111);
    add(14, 1'b0, 1'b1, 1'b1, 4'b0011);
    add(5, 1'b0, 1'b0, 1'b0, 4'b0011);
    add(5, 1'b0, 1'b0, 1'b0, 4'b0000);
    // Bounce 1,1,0,1,1,1,0,0 is rejected.
    add(2, 1'b0, 1'b1, 1'b0, 4'b0000);
    add(1, 1'b0, 1'b0, 1'b0, 4'b0000);
    add(3, 1'b0, 1'b1, 1'b0, 4'b0000);
    add(6, 1'b0, 1'b0, 1'b0, 4'b0000);
    // Exactly five high samples: one pulse, then debounced release.
    add(5, 1'b0, 1'b1, 1'b0, 4'b0000);
    add(1, 1'b0, 1'b0, 1'b0, 4'b1010);
    add(4, 1'b0, 1'b0, 1'b0, 4'b0010);
    add(2, 1'b0, 1'b0, 1'b0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].cb, vecs[i].xb, vecs[i].exp, $sformatf("vec%0d", i));

    // Short release (3 low cycles) must not break the held press.
    hold(5, 1'b0, 1'b1, 1'b0, 4'b0000, "rel_press");
    hold(1, 1'b0, 1'b1, 1'b0, 4'b1010, "rel_pulse1");
    hold(4, 1'b0, 1'b1, 1'b0, 4'b0010, "rel_hold");
    hold(3, 1'b0, 1'b0, 1'b0, 4'b0010, "rel_glitch_low");
    hold(8, 1'b0, 1'b1, 1'b0, 4'b0010, "rel_glitch_high");
    // Long release (6 low cycles) followed by a second press.
    hold(5, 1'b0, 1'b0, 1'b0, 4'b0010, "rel_long_low");
    hold(1, 1'b0, 1'b0, 1'b0, 4'b0000, "rel_level_fall");
    hold(5, 1'b0, 1'b1, 1'b0, 4'b0000, "rel_repress");
    hold(1, 1'b0, 1'b1, 1'b0, 4'b1010, "rel_pulse2");
    hold(2, 1'b0, 1'b1, 1'b0, 4'b0010, "rel_hold2");
    hold(5, 1'b0, 1'b0, 1'b0, 4'b0010, "idle_fall");
    hold(3, 1'b0, 1'b0, 1'b0, 4'b0000, "idle");

    // Reset while the count sits at 2 with call held.
    hold(4, 1'b0, 1'b1, 1'b0, 4'b0000, "mid_count");
    hold(2, 1'b1, 1'b1, 1'b0, 4'b0000, "mid_reset");
    hold(5, 1'b0, 1'b1, 1'b0, 4'b0000, "post_reset");
    hold(1, 1'b0, 1'b1, 1'b0, 4'b1010, "post_reset_pulse");
    hold(2, 1'b0, 1'b1, 1'b0, 4'b0010, "post_reset_hold");

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
